aes_spi_ctrl: RTL
=================

Name: aes_spi_ctrl

Overview:
- SPI-slave front end feeding aes_core; sits directly upstream of the core and also returns its result.
- Receives a 256-bit frame {plaintext, key} from the MCU over an oversampled SPI link.
- Holds the core in load while the frame is received, then releases it to encrypt.
- Latches the cyphertext on core done, flags completion to the MCU, and shifts the cyphertext out full-duplex during the next frame.

Parameters:
- DATA_W, 128, width of key, plaintext and cyphertext words; frame is 2*DATA_W bits.
- SYNC_STAGES, 2, synchronizer depth for sck, sdi and ce (minimum 2).
- TIMEOUT_CYCLES, 64, RUN-state watchdog limit; used only with AES_SPI_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; sck ≤ clk/8.
- reset_n  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock from MCU, asynchronous to clk.
- sdi  in  1  SPI data in, MSB first.
- ce  in  1  frame enable from MCU; high for the whole frame.
- sdo  out  1  SPI data out, registered in the clk domain.
- done_out  out  1  result-ready flag to the MCU.
- err  out  1  watchdog error flag (timeout feature).
- load_out  out  1  drives aes_core load.
- key_out  out  DATA_W  key to the core.
- plaintext_out  out  DATA_W  plaintext to the core.
- done_in  in  1  aes_core done.
- cyphertext_in  in  DATA_W  aes_core cyphertext.

Behaviour:
- Reset (async, reset_n low): state IDLE, load_out=1, done_out=0, err=0, sdo=0, key_out=0, plaintext_out=0, cyphertext latch=0, bit counter=0.
- Synchronization: sck, sdi and ce pass through SYNC_STAGES flops.
- Edge detect: one extra register on synced sck and ce. Rise/fall pulses last one clk.
- States (enum in package): IDLE, RX, RUN, READY.
- IDLE: load_out=1. ce rise → RX, clear bit counter.
- RX: load_out=1.
  - Each sck rise shifts sdi into a 2*DATA_W shift register (LSB in); the counter increments and saturates at 2*DATA_W+1.
  - ce fall with count == 2*DATA_W: latch plaintext_out = shreg[2*DATA_W-1:DATA_W] and key_out = shreg[DATA_W-1:0], then → RUN.
  - ce fall with any other count (short or overrun frame): discard, → IDLE. key_out/plaintext_out unchanged; core stays in load.
- RUN: load_out=0.
  - done_in high → latch cyphertext_in, → READY.
- READY: load_out=0 and done_out=1.
  - ce rise → RX, done_out=0 in the same cycle the state changes. Cyphertext latch is preloaded into the tx shift register.
- Latency: load_out falls exactly SYNC_STAGES+2 clk edges after ce falls at the pin. done_out rises 1 clk after done_in is sampled high.
- sdo:
  - On entry to RX, sdo = tx MSB.
  - Each synced sck fall shifts tx left (zero fill) and sdo takes the new MSB.
  - Bits 0..DATA_W-1 of a frame carry the cyphertext MSB first; the remaining bits are 0.
  - A frame started from IDLE (no result pending) transmits all zeros.
- Simultaneous events:
  - ce fall and a sck rise in the same cycle: the shift is applied first, then the count is checked.
  - ce rise while in RUN is ignored: the MCU must wait for done_out. Stays in RUN.
- Reset mid-frame or mid-RUN: immediate return to reset values; core held in load.

Optional Feature:
- Macro AES_SPI_TIMEOUT_EN.
- Defined: a counter runs in RUN. If done_in has not been seen after TIMEOUT_CYCLES clk, → IDLE (load_out=1) and set err=1. err clears on the next ce rise.
- Undefined: no counter; err tied to 0; RUN waits indefinitely.

Decomposition:
- Package aes_spi_pkg: state enum typedef, FRAME_BITS = 2*DATA_W default constant, TIMEOUT_CYCLES default.
- One sub-module, sync_edge: SYNC_STAGES-deep synchronizer plus rise/fall pulse outputs, instantiated for sck and ce. sdi uses the synchronizer only.

Test Plan:
- FIPS-197 vector, bench pairs the block with aes_core:
  - Reset, then a 256-bit frame with pt=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f.
  - Required: load_out falls, then done_out rises.
  - A second frame returns sdo bits 0..127 = 69c4e0d86a7b0430d8cdb78070b4c55a, followed by 128 zeros.
- Short frame: 200 bits, then ce low → state IDLE, load_out stays 1, done_out=0, key_out/plaintext_out unchanged.
- Overrun frame: 257 bits → discarded, IDLE; a following valid 256-bit frame still encrypts correctly.
- Back-to-back: a second valid frame sent while in READY → done_out drops on ce rise, the new result appears, and the sdo stream equals the first cyphertext.
- Async reset asserted mid-RX (bit 100) and mid-RUN → all outputs at reset values within the same cycle; load_out=1.
- Timeout (with AES_SPI_TIMEOUT_EN): done_in forced 0, valid frame sent → after 64 clk in RUN, err=1 and load_out=1; the next ce rise clears err.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared types and default constants for the aes_spi_ctrl SPI front end.
// The state enum is used by the top-level controller FSM.
package aes_spi_pkg;

  localparam int DEF_DATA_W         = 128;
  localparam int FRAME_BITS         = 2 * DEF_DATA_W;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    RUN   = 2'd2,
    READY = 2'd3
  } state_e;

endpackage

// File: rtl/aes_spi_ctrl_sync_edge.sv
// Multi-flop synchronizer for one asynchronous level, with one-clk rise and
// fall pulses taken from a single extra register after the last stage.
module sync_edge
  import aes_spi_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  if (SYNC_STAGES < 2) begin : g_bad_depth
    $error("sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge value; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/aes_spi_ctrl.sv
// SPI-slave front end for aes_core: receives {plaintext, key}, runs the core and
// returns the cyphertext on sdo. Optional RUN watchdog: define AES_SPI_TIMEOUT_EN.
module aes_spi_ctrl
  import aes_spi_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              sdi,
  input  logic              ce,
  output logic              sdo,
  output logic              done_out,
  output logic              err,
  output logic              load_out,
  output logic [DATA_W-1:0] key_out,
  output logic [DATA_W-1:0] plaintext_out,
  input  logic              done_in,
  input  logic [DATA_W-1:0] cyphertext_in
);

  localparam int FR_W  = 2 * DATA_W;
  localparam int CNT_W = $clog2(FR_W + 2);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("aes_spi_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  logic w_sck_rise, w_sck_fall, w_ce_rise, w_ce_fall;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic w_sdi;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (sck),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ce_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (ce),
    .o_rise  (w_ce_rise),
    .o_fall  (w_ce_fall)
  );

  // Same depth as the sck path so sdi is sampled aligned with the synced rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sdi_sync <= '0;
    else          r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
  end
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  state_e            r_state, w_state_nxt;
  logic [FR_W-1:0]   r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_cnt_nxt;
  logic              w_frame_ok, w_rx_entry, w_timeout;
  logic [DATA_W-1:0] r_tx, r_ct, r_key, r_pt, w_tx_load;
  logic              r_sdo, r_load, r_done;

  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_bit_cnt;
    if (r_state == RX && w_sck_rise) begin
      w_shreg_nxt = {r_shreg[FR_W-2:0], w_sdi};
      if (r_bit_cnt != CNT_W'(FR_W + 1)) w_cnt_nxt = r_bit_cnt + CNT_W'(1);
    end
    // A shift landing with ce fall is counted before the frame length is judged.
    w_frame_ok = (w_cnt_nxt == CNT_W'(FR_W));
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_ce_rise) w_state_nxt = RX;
      RX:      if (w_ce_fall) w_state_nxt = w_frame_ok ? RUN : IDLE;
      RUN: begin
        if (done_in)        w_state_nxt = READY;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      READY:   if (w_ce_rise) w_state_nxt = RX;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  assign w_rx_entry = (r_state != RX) && (w_state_nxt == RX);
  assign w_tx_load  = (r_state == READY) ? r_ct : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_key     <= '0;
      r_pt      <= '0;
      r_ct      <= '0;
      r_tx      <= '0;
      r_sdo     <= 1'b0;
      r_load    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_rx_entry ? '0 : w_cnt_nxt;
      if (r_state == RX && w_ce_fall && w_frame_ok) begin
        r_pt  <= w_shreg_nxt[FR_W-1:DATA_W];
        r_key <= w_shreg_nxt[DATA_W-1:0];
      end
      if (r_state == RUN && done_in) r_ct <= cyphertext_in;
      if (w_rx_entry) begin
        r_tx  <= w_tx_load;
        r_sdo <= w_tx_load[DATA_W-1];
      end else if (r_state == RX && w_sck_fall) begin
        r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
        r_sdo <= r_tx[DATA_W-2];
      end
      // Load follows the registered state, so the core is released one clk
      // after the FSM enters RUN.
      r_load <= (r_state == IDLE) || (r_state == RX);
      r_done <= (w_state_nxt == READY);
    end
  end

`ifdef AES_SPI_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == RUN) ? r_to_cnt + TO_W'(1) : '0;
      if (w_timeout)      r_err <= 1'b1;
      else if (w_ce_rise) r_err <= 1'b0;
    end
  end

  assign w_timeout = (r_state == RUN) && !done_in &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign err       = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign sdo           = r_sdo;
  assign done_out      = r_done;
  assign load_out      = r_load;
  assign key_out       = r_key;
  assign plaintext_out = r_pt;

endmodule
